// File: rtl/softmax_seq_ctrl.sv
// Two-pass softmax sequencer: SUM pass (exp + accumulate), then NORM pass
// (exp recompute + divide), with strobes aligned to fixed pipeline latencies.
module softmax_seq_ctrl #(
  parameter int VEC_LEN = 10,
  parameter int ADDR_W  = 4,
  parameter int EXP_LAT = 23,
  parameter int DIV_LAT = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic              pipe_en,
  output logic              busy,
  output logic              done,
  output logic              phase,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              sum_ld,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        dbg_state
);

  // Host handshake: start is a level sampled only in IDLE on an edge with
  // hold=0; done is a one-cycle pulse in the first IDLE cycle after the last
  // write. A start seen in that done cycle launches the next vector at once.

  localparam int ND   = EXP_LAT + DIV_LAT;
  localparam int DC_W = $clog2(ND + 1);
  localparam logic [ADDR_W-1:0] N_LAST     = ADDR_W'(VEC_LEN - 1);
  localparam logic [DC_W-1:0]   SUM_LD_CNT = DC_W'(EXP_LAT);
  localparam logic [DC_W-1:0]   NORM_LAST  = DC_W'(ND - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SUM        = 3'd1,
    S_DRAIN_SUM  = 3'd2,
    S_NORM       = 3'd3,
    S_DRAIN_NORM = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [DC_W-1:0]   dcnt, dcnt_n;
  logic              done_r, done_n;

  // Delay lines: bit/word 0 of each *_shift is the current-cycle input,
  // the top entry is the fully delayed output.
  logic [EXP_LAT-1:0]             acc_dly;
  logic [EXP_LAT:0]               acc_shift;
  logic [ND-1:0]                  wr_dly;
  logic [ND:0]                    wr_shift;
  logic [ND-1:0][ADDR_W-1:0]      addr_dly;
  logic [ND:0][ADDR_W-1:0]        addr_shift;

  assign acc_shift  = {acc_dly, (state == S_SUM)};
  assign wr_shift   = {wr_dly, (state == S_NORM)};
  assign addr_shift = {addr_dly, cnt};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dcnt     <= '0;
      done_r   <= 1'b0;
      acc_dly  <= '0;
      wr_dly   <= '0;
      addr_dly <= '0;
    end else if (!hold) begin
      state    <= state_n;
      cnt      <= cnt_n;
      dcnt     <= dcnt_n;
      done_r   <= done_n;
      acc_dly  <= acc_shift[EXP_LAT-1:0];
      wr_dly   <= wr_shift[ND-1:0];
      addr_dly <= addr_shift[ND-1:0];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dcnt_n  = dcnt;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SUM;
          cnt_n   = '0;
        end
      end
      S_SUM: begin
        if (cnt == N_LAST) begin
          state_n = S_DRAIN_SUM;
          cnt_n   = '0;
          dcnt_n  = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      // Wait for the last exp result to be accumulated, then latch the sum.
      S_DRAIN_SUM: begin
        if (dcnt == SUM_LD_CNT) begin
          state_n = S_NORM;
          cnt_n   = '0;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      S_NORM: begin
        if (cnt == N_LAST) begin
          state_n = S_DRAIN_NORM;
          cnt_n   = '0;
          dcnt_n  = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN_NORM: begin
        if (dcnt == NORM_LAST) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Strobes are masked by hold; levels and addresses simply hold their value.
  assign pipe_en   = ~hold;
  assign busy      = (state != S_IDLE);
  assign phase     = (state == S_NORM) || (state == S_DRAIN_NORM);
  assign rd_en     = ((state == S_SUM) || (state == S_NORM)) && !hold;
  assign rd_addr   = cnt;
  assign acc_clr   = (state == S_SUM) && (cnt == '0) && !hold;
  assign acc_en    = acc_shift[EXP_LAT] && !hold;
  assign sum_ld    = (state == S_DRAIN_SUM) && (dcnt == SUM_LD_CNT) && !hold;
  assign wr_en     = wr_shift[ND] && !hold;
  assign wr_addr   = addr_shift[ND];
  assign done      = done_r && !hold;
  assign dbg_state = state;

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Bench for softmax_seq_ctrl: a timeline model indexed by the count of
// non-held cycles since start predicts every output on every cycle.
module tb_softmax_seq_ctrl;

  localparam int N  = 10;
  localparam int E  = 23;
  localparam int D  = 23;
  localparam int AW = 4;
  localparam int N1 = 1;
  localparam int AW1 = 1;
  localparam int TOT  = 2*N  + 2*E + D + 2;
  localparam int TOT1 = 2*N1 + 2*E + D + 2;

  // clock / reset / stimulus
  logic clk = 1'b0;
  logic rst_n, start, hold, start1, hold1;
  always #5 clk = ~clk;

  logic          pipe_en, busy, done, phase, rd_en, acc_clr, acc_en, sum_ld, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [2:0]    dbg_state;
  logic           s_pipe_en, s_busy, s_done, s_phase, s_rd_en, s_acc_clr, s_acc_en, s_sum_ld, s_wr_en;
  logic [AW1-1:0] s_rd_addr, s_wr_addr;
  logic [2:0]     s_dbg_state;

  softmax_seq_ctrl #(.VEC_LEN(N), .ADDR_W(AW), .EXP_LAT(E), .DIV_LAT(D)) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .hold(hold), .pipe_en(pipe_en),
    .busy(busy), .done(done), .phase(phase), .rd_en(rd_en), .rd_addr(rd_addr),
    .acc_clr(acc_clr), .acc_en(acc_en), .sum_ld(sum_ld), .wr_en(wr_en),
    .wr_addr(wr_addr), .dbg_state(dbg_state));

  softmax_seq_ctrl #(.VEC_LEN(N1), .ADDR_W(AW1), .EXP_LAT(E), .DIV_LAT(D)) u_small (
    .clk(clk), .reset(rst_n), .start(start1), .hold(hold1), .pipe_en(s_pipe_en),
    .busy(s_busy), .done(s_done), .phase(s_phase), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .acc_clr(s_acc_clr), .acc_en(s_acc_en), .sum_ld(s_sum_ld), .wr_en(s_wr_en),
    .wr_addr(s_wr_addr), .dbg_state(s_dbg_state));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t = 0;
  int t1 = 0;

  // Reference model. t = enabled cycles since the accepting edge (1 = first
  // SUM cycle, tot = done cycle, 0 = idle).
  function automatic int next_t(int tc, logic r, logic h, logic s, int tot);
    if (!r) return 0;
    if (h) return tc;
    if ((tc == 0 || tc == tot) && s) return 1;
    if (tc > 0 && tc < tot) return tc + 1;
    return 0;
  endfunction

  function automatic logic [8:0] exp_ctl(int tc, logic r, logic h, int n, int e, int d);
    int tt;
    logic b, dn, ph, re, ac, ae, sl, we;
    tt = 2*n + 2*e + d + 2;
    if (!r) return {~h, 8'b0};
    b  = (tc >= 1) && (tc <= tt - 1);
    dn = (tc == tt) && !h;
    ph = (tc >= n + e + 2) && (tc <= tt - 1);
    re = (((tc >= 1) && (tc <= n)) || ((tc >= n + e + 2) && (tc <= 2*n + e + 1))) && !h;
    ac = (tc == 1) && !h;
    ae = (tc >= 1 + e) && (tc <= n + e) && !h;
    sl = (tc == n + e + 1) && !h;
    we = (tc >= n + 2*e + d + 2) && (tc <= tt - 1) && !h;
    return {~h, b, dn, ph, re, ac, ae, sl, we};
  endfunction

  // -1 means the address is unspecified at this point of the timeline.
  function automatic int exp_rda(int tc, logic r, int n, int e);
    if (!r) return 0;
    if (tc >= 1 && tc <= n) return tc - 1;
    if (tc >= n + e + 2 && tc <= 2*n + e + 1) return tc - (n + e + 2);
    return -1;
  endfunction

  function automatic int exp_wra(int tc, logic r, int n, int e, int d);
    if (!r) return 0;
    if (tc >= n + 2*e + d + 2 && tc <= 2*n + 2*e + d + 1) return tc - (n + 2*e + d + 2);
    return -1;
  endfunction

  function automatic logic [8:0] obs_a();
    return {pipe_en, busy, done, phase, rd_en, acc_clr, acc_en, sum_ld, wr_en};
  endfunction

  function automatic logic [8:0] obs_s();
    return {s_pipe_en, s_busy, s_done, s_phase, s_rd_en, s_acc_clr, s_acc_en, s_sum_ld, s_wr_en};
  endfunction

  // Driver: advance the model across the edge, drive the next cycle's inputs
  // just after it, and return at the falling edge for sampling.
  task automatic step(input logic r, input logic h, input logic s, input logic h1, input logic s1);
    @(posedge clk);
    t  = next_t(t,  rst_n, hold,  start,  TOT);
    t1 = next_t(t1, rst_n, hold1, start1, TOT1);
    #1;
    rst_n = r; hold = h; start = s; hold1 = h1; start1 = s1;
    if (!r) begin t = 0; t1 = 0; end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] ec;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      else step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      ec = exp_ctl(t, rst_n, hold, N, E, D);
      checks++;
      if (obs_a() !== ec) begin
        errors++;
        $display("FAIL reset_ctl cyc=%0d got=%b exp=%b", cyc, obs_a(), ec);
      end
      checks++;
      if (rd_addr !== '0 || wr_addr !== '0) begin
        errors++;
        $display("FAIL reset_addr cyc=%0d got rd=%0d wr=%0d exp 0", cyc, rd_addr, wr_addr);
      end
    end
  endtask

  // Runs len cycles; start/hold/reset come from the cycle index windows given.
  task automatic test_timeline(input string nm, input int len, input int st_a, input int st_b,
                               input int st_c, input int h_lo, input int h_hi,
                               input int r_lo, input int r_hi);
    logic [8:0] ec;
    int ra, wa;
    for (int c = 0; c < len; c++) begin
      step(!(c >= r_lo && c <= r_hi), (c >= h_lo && c <= h_hi),
           (c == st_a) || (c == st_b) || (c == st_c), 1'b0, 1'b0);
      ec = exp_ctl(t, rst_n, hold, N, E, D);
      checks++;
      if (obs_a() !== ec) begin
        errors++;
        $display("FAIL %s ctl cyc=%0d t=%0d got=%b exp=%b", nm, c, t, obs_a(), ec);
      end
      ra = exp_rda(t, rst_n, N, E);
      if (ra >= 0) begin
        checks++;
        if (rd_addr !== AW'(ra)) begin
          errors++;
          $display("FAIL %s rd_addr cyc=%0d t=%0d got=%0d exp=%0d", nm, c, t, rd_addr, ra);
        end
      end
      wa = exp_wra(t, rst_n, N, E, D);
      if (wa >= 0) begin
        checks++;
        if (wr_addr !== AW'(wa)) begin
          errors++;
          $display("FAIL %s wr_addr cyc=%0d t=%0d got=%0d exp=%0d", nm, c, t, wr_addr, wa);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] ec;
    int ra, wa, dones;
    dones = 0;
    for (int c = 0; c < 2*TOT + 6; c++) begin
      step(1'b1, 1'b0, (c <= TOT + 1), 1'b0, 1'b0);
      ec = exp_ctl(t, rst_n, hold, N, E, D);
      dones += int'(done);
      checks++;
      if (obs_a() !== ec) begin
        errors++;
        $display("FAIL b2b ctl cyc=%0d t=%0d got=%b exp=%b", c, t, obs_a(), ec);
      end
      ra = exp_rda(t, rst_n, N, E);
      wa = exp_wra(t, rst_n, N, E, D);
      if (ra >= 0) begin
        checks++;
        if (rd_addr !== AW'(ra)) begin
          errors++;
          $display("FAIL b2b rd_addr cyc=%0d got=%0d exp=%0d", c, rd_addr, ra);
        end
      end
      if (wa >= 0) begin
        checks++;
        if (wr_addr !== AW'(wa)) begin
          errors++;
          $display("FAIL b2b wr_addr cyc=%0d got=%0d exp=%0d", c, wr_addr, wa);
        end
      end
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b done_count got=%0d exp=2", dones);
    end
  endtask

  task automatic test_vec_len1();
    logic [8:0] ec;
    int ra, wa;
    for (int c = 0; c < TOT1 + 4; c++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, (c == 0));
      ec = exp_ctl(t1, rst_n, hold1, N1, E, D);
      checks++;
      if (obs_s() !== ec) begin
        errors++;
        $display("FAIL len1 ctl cyc=%0d t=%0d got=%b exp=%b", c, t1, obs_s(), ec);
      end
      ra = exp_rda(t1, rst_n, N1, E);
      wa = exp_wra(t1, rst_n, N1, E, D);
      if (ra >= 0) begin
        checks++;
        if (s_rd_addr !== AW1'(ra)) begin
          errors++;
          $display("FAIL len1 rd_addr cyc=%0d got=%0d exp=%0d", c, s_rd_addr, ra);
        end
      end
      if (wa >= 0) begin
        checks++;
        if (s_wr_addr !== AW1'(wa)) begin
          errors++;
          $display("FAIL len1 wr_addr cyc=%0d got=%0d exp=%0d", c, s_wr_addr, wa);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] ec, es;
    int ra, wa;
    for (int c = 0; c < 1500; c++) begin
      step(($urandom_range(0, 399) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
      ec = exp_ctl(t, rst_n, hold, N, E, D);
      es = exp_ctl(t1, rst_n, hold1, N1, E, D);
      checks += 2;
      if (obs_a() !== ec) begin
        errors++;
        $display("FAIL rand ctl cyc=%0d t=%0d got=%b exp=%b", c, t, obs_a(), ec);
      end
      if (obs_s() !== es) begin
        errors++;
        $display("FAIL rand len1_ctl cyc=%0d t=%0d got=%b exp=%b", c, t1, obs_s(), es);
      end
      ra = exp_rda(t, rst_n, N, E);
      wa = exp_wra(t, rst_n, N, E, D);
      if (ra >= 0) begin
        checks++;
        if (rd_addr !== AW'(ra)) begin
          errors++;
          $display("FAIL rand rd_addr cyc=%0d got=%0d exp=%0d", c, rd_addr, ra);
        end
      end
      if (wa >= 0) begin
        checks++;
        if (wr_addr !== AW'(wa)) begin
          errors++;
          $display("FAIL rand wr_addr cyc=%0d got=%0d exp=%0d", c, wr_addr, wa);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; start = 1'b0; hold1 = 1'b0; start1 = 1'b0;
    test_reset();
    test_timeline("single", TOT + 4, 0, -1, -1, -1, -1, -1, -1);
    test_timeline("start_busy", TOT + 4, 0, 5, 40, -1, -1, -1, -1);
    test_back_to_back();
    test_timeline("hold_sum", TOT + 10, 0, -1, -1, 4, 8, -1, -1);
    test_timeline("hold_norm", TOT + 10, 0, -1, -1, 50, 53, -1, -1);
    test_timeline("reset_mid", 60, 0, -1, -1, -1, -1, 40, 41);
    test_timeline("after_reset", TOT + 4, 0, -1, -1, -1, -1, -1, -1);
    test_vec_len1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
